sc_decode_et: RTL

//  Stochastic-to-binary decoder (SC counter) for early-terminated bitstreams.
//  - Counts ones in one SC output stream, e.g. a gate fed by cape_ET Xs.
//  - On the last beat, normalises the count by the observed stream length.
//  - Stream length is 2^k; it shrinks with input precision and trunc.
//  - Emits a CNT_WIDTH-bit fixed-point binary result, value = Bz / 2^CNT_WIDTH.

---
 rtl/sc_et_pkg.sv | 18 +
 rtl/sc_log2_pow2.sv | 26 ++
 rtl/sc_decode_et.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/sc_et_pkg.sv
// Shared types and helpers for the stochastic-computing early-termination blocks.
//  - sc_dec_state_t : decoder FSM states
//  - cnt_width()    : stream counter width derived from encoder geometry
package sc_et_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        NORM  = 2'd2
    } sc_dec_state_t;

    // Full-precision stream length is 2^(width*num_inputs) beats.
    function automatic int unsigned cnt_width(input int unsigned width,
                                              input int unsigned num_inputs);
        return width * num_inputs;
    endfunction

endpackage

// File: rtl/sc_log2_pow2.sv
// Combinational log2 of a nonzero count plus a power-of-two flag.
//  x       : value to inspect
//  k       : index of the most significant set bit (floor(log2(x)))
//  is_pow2 : x has exactly one bit set
module sc_log2_pow2 #(
    parameter int unsigned IN_W = 9,
    parameter int unsigned K_W  = $clog2(IN_W)
) (
    input  logic [IN_W-1:0] x,
    output logic [K_W-1:0]  k,
    output logic            is_pow2
);

    // MSB priority encode: the highest set bit wins because it is assigned last.
    always_comb begin
        k = '0;
        for (int i = 0; i < int'(IN_W); i++) begin
            if (x[i]) begin
                k = K_W'(i);
            end
        end
    end

    assign is_pow2 = (x != '0) && ((x & (x - IN_W'(1))) == '0);

endmodule

// File: rtl/sc_decode_et.sv
// Stochastic-to-binary decoder for early-terminated bitstreams.
// Counts ones in one SC stream and, on the last beat, normalises the count
// by the observed (power-of-two) stream length into a CNT_WIDTH-bit fraction.
//  clk, rst                 : clock, synchronous active-high reset
//  start                    : clears counters and begins a new stream
//  z_valid, z, z_last       : stream beat, bit, and final-beat marker
//  busy                     : stream in progress (ACCUM or NORM)
//  Bz, Bz_valid             : decoded value and its one-cycle strobe
//  len_log2                 : log2 of the last stream length
//  err                      : sticky until start; overflow or non-power-of-two length
module sc_decode_et
    import sc_et_pkg::*;
#(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned NUM_INPUTS = 2,
    parameter int unsigned CNT_WIDTH  = cnt_width(WIDTH, NUM_INPUTS)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic                             z_valid,
    input  logic                             z,
    input  logic                             z_last,
    output logic                             busy,
    output logic [CNT_WIDTH-1:0]             Bz,
    output logic                             Bz_valid,
    output logic [$clog2(CNT_WIDTH+1)-1:0]   len_log2,
    output logic                             err
);

    localparam int unsigned CW1 = CNT_WIDTH + 1;
    localparam int unsigned KW  = $clog2(CNT_WIDTH + 1);
    localparam logic [CW1-1:0] FULL_LEN = CW1'(1) << CNT_WIDTH;

    sc_dec_state_t        state_q, state_d;
    logic [CW1-1:0]       ones_q, ones_d;
    logic [CW1-1:0]       cycles_q, cycles_d;
    logic [CNT_WIDTH-1:0] bz_q, bz_d;
    logic                 bz_valid_q, bz_valid_d;
    logic [KW-1:0]        len_q, len_d;
    logic                 err_q, err_d;
    logic                 busy_q, busy_d;

    logic [KW-1:0]        k;
    logic                 is_pow2;
    logic [KW-1:0]        shamt;
    logic [CW1-1:0]       scaled;
    logic                 accept;

    sc_log2_pow2 #(
        .IN_W (CW1),
        .K_W  (KW)
    ) u_log2 (
        .x       (cycles_q),
        .k       (k),
        .is_pow2 (is_pow2)
    );

    // Scale ones up to a CNT_WIDTH-bit fraction of the 2^k stream length.
    assign shamt  = KW'(CNT_WIDTH) - k;
    assign scaled = ones_q << shamt;

    // Next-state and output computation.
    always_comb begin
        state_d    = state_q;
        ones_d     = ones_q;
        cycles_d   = cycles_q;
        bz_d       = bz_q;
        bz_valid_d = 1'b0;
        len_d      = len_q;
        err_d      = err_q;
        accept     = 1'b0;

        if (start) begin
            // Start wins over any in-flight stream; its result is dropped.
            ones_d   = '0;
            cycles_d = '0;
            err_d    = 1'b0;
            state_d  = ACCUM;
            accept   = z_valid;
        end else begin
            case (state_q)
                ACCUM: accept = z_valid;
                NORM: begin
                    state_d    = IDLE;
                    bz_valid_d = 1'b1;
                    len_d      = k;
                    bz_d       = (ones_q == cycles_q) ? '1 : scaled[CNT_WIDTH-1:0];
                    if (!is_pow2) begin
                        err_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        if (accept) begin
            // Once the counter is full further beats are flagged, not counted.
            if (cycles_d == FULL_LEN) begin
                err_d = 1'b1;
            end else begin
                ones_d   = ones_d + CW1'(z);
                cycles_d = cycles_d + CW1'(1);
            end
            if (z_last) begin
                state_d = NORM;
            end
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ones_q     <= '0;
            cycles_q   <= '0;
            bz_q       <= '0;
            bz_valid_q <= 1'b0;
            len_q      <= '0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ones_q     <= ones_d;
            cycles_q   <= cycles_d;
            bz_q       <= bz_d;
            bz_valid_q <= bz_valid_d;
            len_q      <= len_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
        end
    end

    assign busy     = busy_q;
    assign Bz       = bz_q;
    assign Bz_valid = bz_valid_q;
    assign len_log2 = len_q;
    assign err      = err_q;

endmodule
